top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 Parameter UART_DIV, default 234: clk cycles per UART bit (27 MHz / 115200).
REQ-002 Parameter TEXT_LEN, default 19: number of character cells in text memory.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 flashMiso  input  1  SPI flash serial data out (to this block).
REQ-006 flashClk  output  1  SPI clock, mode 0, idle low.
REQ-007 flashMosi  output  1  SPI serial data (from this block).
REQ-008 flashCs  output  1  SPI chip select, active-low.
REQ-009 uart_rx  input  1  UART receive, 8N1, idle high.
REQ-010 uart_tx  output  1  UART transmit, 8N1, idle high.
REQ-011 btnDownR, btnUpR, btnLeftR, btnRightR  input  1 each  push buttons, active-low (1 = released).
REQ-012 led  output  6  status LEDs, active-low (0 = lit).
REQ-013 Instance cpu_1.cpu_regs SHALL hold the register array data[0:31], 32 bits each; instance text SHALL hold charMemory[0:TEXT_LEN-1], 8 bits each; both SHALL be readable hierarchically by the bench.

Function
REQ-014 Boot FSM states: IDLE -> CMD -> READ -> DONE; IDLE is left on the first clk after reset deasserts.
REQ-015 CMD: flashCs low, shift 0x03 followed by 24-bit address 0x000000, MSB first; flashMosi changes only while flashClk is low.
REQ-016 flashClk SHALL be clk/2 (toggles every clk) during CMD and READ, low otherwise.
REQ-017 READ: sample flashMiso on each flashClk rising edge, MSB first; 124 bytes.
REQ-018 Bytes SHALL be packed little-endian into words: bytes 4k..4k+3 -> data[k+1], k = 0..30.
REQ-019 Each word SHALL be written on the clk following its 4th byte.
REQ-020 data[0] SHALL stay 0 forever.
REQ-021 After the last byte: flashCs high, flashClk low, state DONE; DONE SHALL be held until reset.
REQ-022 uart_rx SHALL pass through a 2-flop synchronizer.
REQ-023 UART RX start detection: a falling edge, confirmed low at half a bit period.
REQ-024 UART RX sampling: 8 data bits LSB first, each at mid-bit, then the stop bit.
REQ-025 A byte with a stop bit of 0 (framing error) SHALL be discarded.
REQ-026 Accepted byte != 0x0D SHALL be written to charMemory[wptr], then wptr increments; wptr wraps TEXT_LEN-1 -> 0.
REQ-027 Accepted byte 0x0D SHALL set wptr to 0 and write nothing.
REQ-028 Every accepted byte (including 0x0D) SHALL be echoed on uart_tx (start bit, 8 data bits LSB first, 1 stop bit, UART_DIV clks per bit).
REQ-029 If TX is busy when a byte is accepted, its echo SHALL be dropped.
REQ-030 UART is active regardless of boot state.
REQ-031 Buttons SHALL be 2-flop synchronized.
REQ-032 LED mapping: led[0..3] = synchronized btnDownR, btnUpR, btnLeftR, btnRightR (pressed -> lit).
REQ-033 led[4] SHALL be lit in DONE.
REQ-034 led[5] SHALL toggle on each accepted byte.

Reset
REQ-035 On reset low, asynchronously: flashCs=1, flashClk=0, flashMosi=0, uart_tx=1, led=6'b111111, FSM=IDLE, wptr=0, all data[]=0, all charMemory[]=0x20, RX/TX idle.
REQ-036 Reset asserted mid-boot or mid-UART-frame SHALL abort the operation and restart from the reset state.

Verification
REQ-037 Flash model returns bytes n = 0..123 as value n; after boot -> data[1]=0x03020100, data[31]=0x7B7A7978, data[0]=0, led[4]=0, flashCs=1.
REQ-038 Check the first 32 flashMosi bits -> 0x03000000; first flashClk rise no earlier than the clk after flashCs falls.
REQ-039 Send "HELLO" -> charMemory[0..4]="HELLO", [5..18]=0x20; echo frames on uart_tx equal "HELLO"; led[5] toggled 5 times.
REQ-040 Send 20 x 'A' then 'B' -> charMemory[0]='A', charMemory[1]='B' (wrap); send 0x0D then 'Z' -> charMemory[0]='Z'.
REQ-041 Frame with stop bit 0 -> charMemory and wptr unchanged, no echo.
REQ-042 All buttons 1 -> led[3:0]=4'b1111; btnUpR=0 -> led[1]=0 within 3 clks; reset pulse mid-READ -> all outputs at reset values, then boot restarts.

Source files
------------

// File: rtl/top.sv
// top: SPI-flash boot loader filling a 32-word register file, plus a UART text console
// that stores received characters and echoes them back.
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);
  logic [31:0] data [0:31];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < 32; i++) data[i] <= '0;
    end else begin
      data[0] <= '0;
      for (int i = 1; i < 32; i++) data[i] <= (we && waddr == 5'(i)) ? wdata : data[i];
    end
endmodule

module cpu (
  input  logic clk,
  input  logic reset,
  input  logic flash_miso,
  output logic flash_clk,
  output logic flash_mosi,
  output logic flash_cs,
  output logic done
);
  typedef enum logic [1:0] {IDLE, CMD, READ, DONE} state_t;
  localparam logic [31:0] READ_CMD = 32'h0300_0000;
  localparam logic [9:0] READ_BITS = 10'd992;
  state_t state;
  logic [31:0] cmd_sr, word;
  logic [9:0] cnt;
  logic [6:0] byte_sr;
  logic [7:0] new_byte;
  logic we;
  logic [4:0] waddr;
  assign new_byte = {byte_sr, flash_miso};
  assign done = state == DONE;
  regfile cpu_regs (.clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(word));
  // flash_clk is toggled by this FSM: mosi moves on its falling side, miso is taken on its rising side
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      flash_cs <= 1'b1;
      flash_clk <= 1'b0;
      flash_mosi <= 1'b0;
      cmd_sr <= '0;
      word <= '0;
      cnt <= '0;
      byte_sr <= '0;
      we <= 1'b0;
      waddr <= '0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE: begin
          state <= CMD;
          flash_cs <= 1'b0;
          flash_mosi <= READ_CMD[31];
          cmd_sr <= {READ_CMD[30:0], 1'b0};
          cnt <= '0;
        end
        CMD: begin
          flash_clk <= ~flash_clk;
          if (flash_clk) begin
            state <= cnt == 10'd31 ? READ : CMD;
            flash_mosi <= cnt == 10'd31 ? 1'b0 : cmd_sr[31];
            cmd_sr <= cmd_sr << 1;
            cnt <= cnt == 10'd31 ? '0 : cnt + 10'd1;
          end
        end
        READ: begin
          if (!flash_clk) begin
            flash_clk <= 1'b1;
            byte_sr <= new_byte[6:0];
            cnt <= cnt + 10'd1;
            if (cnt[2:0] == 3'd7) begin
              word <= {new_byte, word[31:8]};
              we <= cnt[4:3] == 2'd3;
              waddr <= cnt[9:5] + 5'd1;
            end
          end else begin
            flash_clk <= 1'b0;
            flash_cs <= cnt == READ_BITS;
            state <= cnt == READ_BITS ? DONE : READ;
          end
        end
        DONE: state <= DONE;
      endcase
    end
endmodule

module uart_receiver #(parameter int DIV = 234) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       valid,
  output logic [7:0] data
);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  localparam logic [15:0] FULL = 16'(DIV - 1);
  localparam logic [15:0] MID = 16'(DIV / 2 - 2);
  rx_state_t st;
  logic [1:0] sync;
  logic prev;
  logic [15:0] cnt;
  logic [2:0] nbit;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync <= 2'b11;
      prev <= 1'b1;
      st <= R_IDLE;
      cnt <= '0;
      nbit <= '0;
      valid <= 1'b0;
      data <= '0;
    end else begin
      sync <= {sync[0], rx};
      prev <= sync[1];
      valid <= 1'b0;
      case (st)
        R_IDLE: begin
          st <= (prev && !sync[1]) ? R_START : R_IDLE;
          cnt <= '0;
        end
        R_START: begin
          st <= cnt == MID ? (sync[1] ? R_IDLE : R_DATA) : R_START;
          cnt <= cnt == MID ? '0 : cnt + 16'd1;
          nbit <= '0;
        end
        R_DATA: begin
          cnt <= cnt == FULL ? '0 : cnt + 16'd1;
          if (cnt == FULL) begin
            data <= {sync[1], data[7:1]};
            nbit <= nbit + 3'd1;
            st <= nbit == 3'd7 ? R_STOP : R_DATA;
          end
        end
        R_STOP: begin
          cnt <= cnt == FULL ? '0 : cnt + 16'd1;
          valid <= cnt == FULL && sync[1];
          st <= cnt == FULL ? R_IDLE : R_STOP;
        end
      endcase
    end
endmodule

module uart_transmitter #(parameter int DIV = 234) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       busy
);
  localparam logic [15:0] FULL = 16'(DIV - 1);
  logic [8:0] sh;
  logic [3:0] n;
  logic [15:0] cnt;
  // sh holds the data bits followed by the stop bit; n counts bits still to be shifted out
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tx <= 1'b1;
      busy <= 1'b0;
      sh <= '1;
      n <= '0;
      cnt <= '0;
    end else if (!busy) begin
      if (start) begin
        busy <= 1'b1;
        tx <= 1'b0;
        sh <= {1'b1, din};
        n <= 4'd9;
        cnt <= '0;
      end
    end else if (cnt == FULL) begin
      cnt <= '0;
      busy <= n != 4'd0;
      if (n != 4'd0) begin
        tx <= sh[0];
        sh <= {1'b1, sh[8:1]};
        n <= n - 4'd1;
      end
    end else begin
      cnt <= cnt + 16'd1;
    end
endmodule

module text_mem #(parameter int LEN = 19) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] din
);
  localparam int AW = (LEN > 1) ? $clog2(LEN) : 1;
  logic [7:0] charMemory [0:LEN-1];
  logic [AW-1:0] wptr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr <= '0;
      for (int i = 0; i < LEN; i++) charMemory[i] <= 8'h20;
    end else if (we) begin
      wptr <= (din == 8'h0D || wptr == AW'(LEN - 1)) ? '0 : wptr + AW'(1);
      for (int i = 0; i < LEN; i++) charMemory[i] <= (din != 8'h0D && wptr == AW'(i)) ? din : charMemory[i];
    end
endmodule

module top #(
  parameter int UART_DIV = 234,
  parameter int TEXT_LEN = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flashMiso,
  output logic       flashClk,
  output logic       flashMosi,
  output logic       flashCs,
  input  logic       uart_rx,
  output logic       uart_tx,
  input  logic       btnDownR,
  input  logic       btnUpR,
  input  logic       btnLeftR,
  input  logic       btnRightR,
  output logic [5:0] led
);
  logic done, rx_valid, tx_busy, led5;
  logic [7:0] rx_data;
  logic [3:0] btn_s0, btn_s1;
  cpu cpu_1 (
    .clk(clk), .reset(reset), .flash_miso(flashMiso), .flash_clk(flashClk),
    .flash_mosi(flashMosi), .flash_cs(flashCs), .done(done)
  );
  uart_receiver #(.DIV(UART_DIV)) rx_i (
    .clk(clk), .reset(reset), .rx(uart_rx), .valid(rx_valid), .data(rx_data)
  );
  uart_transmitter #(.DIV(UART_DIV)) tx_i (
    .clk(clk), .reset(reset), .start(rx_valid), .din(rx_data), .tx(uart_tx), .busy(tx_busy)
  );
  text_mem #(.LEN(TEXT_LEN)) text (.clk(clk), .reset(reset), .we(rx_valid), .din(rx_data));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      btn_s0 <= 4'hf;
      btn_s1 <= 4'hf;
      led5 <= 1'b1;
    end else begin
      btn_s0 <= {btnRightR, btnLeftR, btnUpR, btnDownR};
      btn_s1 <= btn_s0;
      led5 <= led5 ^ rx_valid;
    end
  assign led = {led5, ~done, btn_s1};
endmodule

// File: tb/tb_top.sv
// tb_top: flash-model boot check, table-driven UART vectors with an echo scoreboard, buttons and reset.
module tb_top;
  localparam int DIV = 16;
  localparam int LEN = 19;
  logic clk = 0, reset = 0, flashMiso = 0, uart_rx = 1;
  logic btnDownR = 1, btnUpR = 1, btnLeftR = 1, btnRightR = 1;
  logic flashClk, flashMosi, flashCs, uart_tx;
  logic [5:0] led;
  int n_cmp = 0, n_bad = 0;
  int rises = 0, mosi_viol = 0;
  time t_cs = 0;
  logic [31:0] mosi_cap = '0;
  logic mosi_prev = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic [7:0] d;
    logic       ok;
    int         idx;
    logic [7:0] exp;
  } vec_t;
  vec_t v [$];

  top #(.UART_DIV(DIV), .TEXT_LEN(LEN)) dut (
    .clk(clk), .reset(reset), .flashMiso(flashMiso), .flashClk(flashClk),
    .flashMosi(flashMosi), .flashCs(flashCs), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .btnDownR(btnDownR), .btnUpR(btnUpR), .btnLeftR(btnLeftR), .btnRightR(btnRightR),
    .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // flash model: captures the command, then serves byte n = n, MSB first, changing on falling SCK
  always @(negedge flashCs) begin
    t_cs = $time;
    rises = 0;
  end
  always @(posedge flashCs) rises = 0;
  always @(posedge flashClk)
    if (!flashCs) begin
      if (rises == 0) check("cs_to_first_sck", 32'($time - t_cs >= 10), 1);
      if (rises < 32) mosi_cap = {mosi_cap[30:0], flashMosi};
      if (rises == 31) check("cmd_bits", mosi_cap, 32'h0300_0000);
      rises++;
    end
  always @(negedge flashClk) begin : miso_drv
    int idx;
    logic [7:0] b;
    if (!flashCs && rises >= 32) begin
      idx = rises - 32;
      b = 8'(idx / 8);
      flashMiso = b[7 - idx % 8];
    end
  end
  always @(negedge clk) begin
    if (!flashCs && flashClk && flashMosi !== mosi_prev) mosi_viol++;
    mosi_prev = flashMosi;
  end

  // echo monitor: decodes uart_tx frames and pops the scoreboard
  initial forever begin : echo_mon
    logic [7:0] d;
    @(negedge uart_tx);
    repeat (DIV / 2) @(negedge clk);
    if (uart_tx == 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        d[i] = uart_tx;
      end
      repeat (DIV) @(negedge clk);
      check("echo_stop", {31'd0, uart_tx}, 1);
      check("echo_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) check("echo_data", {24'd0, d}, {24'd0, sb.pop_front()});
    end
  end

  task automatic send(input logic [7:0] d, input logic ok);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = ok;
    repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (led[4] !== 1'b0 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check(name, {31'd0, led[4]}, 0);
  endtask

  task automatic check_words(input string name);
    for (int k = 0; k < 31; k++)
      check($sformatf("%s_data%0d", name, k + 1), dut.cpu_1.cpu_regs.data[k + 1],
            {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)});
    check($sformatf("%s_data0", name), dut.cpu_1.cpu_regs.data[0], 0);
  endtask

  function automatic void add(input logic [7:0] d, input logic ok, input int idx, input logic [7:0] exp);
    vec_t t;
    t.d = d;
    t.ok = ok;
    t.idx = idx;
    t.exp = exp;
    v.push_back(t);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    string hello;
    logic led5_exp;
    logic [3:0] m;
    hello = "HELLO";
    for (int i = 0; i < 5; i++) add(hello[i], 1, i, hello[i]);
    add(8'h0D, 1, 0, "H");
    for (int i = 0; i < 20; i++) add("A", 1, i % 19, "A");
    add("B", 1, 1, "B");
    add(8'h0D, 1, 1, "B");
    add("Z", 1, 0, "Z");
    add("Q", 0, 1, "B");
    add("C", 1, 1, "C");

    repeat (3) @(negedge clk);
    check("rst_cs", {31'd0, flashCs}, 1);
    check("rst_sck", {31'd0, flashClk}, 0);
    check("rst_mosi", {31'd0, flashMosi}, 0);
    check("rst_tx", {31'd0, uart_tx}, 1);
    check("rst_led", {26'd0, led}, 32'h3f);
    for (int k = 0; k < 32; k++) check("rst_data", dut.cpu_1.cpu_regs.data[k], 0);
    for (int k = 0; k < LEN; k++) check("rst_char", {24'd0, dut.text.charMemory[k]}, 32'h20);
    reset = 1;

    wait_done("boot_done");
    check_words("boot");
    check("boot_cs", {31'd0, flashCs}, 1);
    check("boot_sck", {31'd0, flashClk}, 0);
    check("mosi_stable_while_sck_high", mosi_viol, 0);

    led5_exp = 1'b1;
    foreach (v[i]) begin
      if (v[i].ok) begin
        sb.push_back(v[i].d);
        led5_exp = ~led5_exp;
      end
      send(v[i].d, v[i].ok);
      check($sformatf("vec%0d_char%0d", i, v[i].idx), {24'd0, dut.text.charMemory[v[i].idx]}, {24'd0, v[i].exp});
      check($sformatf("vec%0d_led5", i), {31'd0, led[5]}, {31'd0, led5_exp});
      if (i == 4) for (int k = 5; k < LEN; k++) check("hello_blank", {24'd0, dut.text.charMemory[k]}, 32'h20);
    end
    repeat (12 * DIV) @(negedge clk);
    check("echo_all_seen", sb.size(), 0);

    check("btn_idle", {28'd0, led[3:0]}, 32'hf);
    for (int i = 0; i < 4; i++) begin
      m = ~(4'b1 << i);
      {btnRightR, btnLeftR, btnUpR, btnDownR} = m;
      repeat (3) @(negedge clk);
      check($sformatf("btn%0d", i), {28'd0, led[3:0]}, {28'd0, m});
    end
    {btnRightR, btnLeftR, btnUpR, btnDownR} = 4'hf;
    repeat (3) @(negedge clk);
    check("btn_release", {28'd0, led[3:0]}, 32'hf);

    reset = 0;
    @(negedge clk);
    reset = 1;
    repeat (300) @(negedge clk);
    check("midread_cs_low", {31'd0, flashCs}, 0);
    reset = 0;
    #2;
    check("midrst_cs", {31'd0, flashCs}, 1);
    check("midrst_sck", {31'd0, flashClk}, 0);
    check("midrst_mosi", {31'd0, flashMosi}, 0);
    check("midrst_tx", {31'd0, uart_tx}, 1);
    check("midrst_led", {26'd0, led}, 32'h3f);
    check("midrst_data1", dut.cpu_1.cpu_regs.data[1], 0);
    check("midrst_char0", {24'd0, dut.text.charMemory[0]}, 32'h20);
    @(negedge clk);
    reset = 1;
    wait_done("reboot_done");
    check_words("reboot");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
